iob_regfile_sp_arb: RTL and testbench
=====================================

Name: iob_regfile_sp_arb

Overview:
Controller in front of a single-port register file, of the kind used inside the cache block.
- Shares the one read/write port between two requesters using round-robin arbitration with valid/ready handshakes.
- Returns read data on a registered response channel.
- Contains a flush sequencer that walks every address and writes zero.
- Sits between the cache control logic (requester 0), the write-buffer/replacement logic (requester 1) and the register file instance.

Parameters:
ADDR_W, 2, register file address width; depth = 2**ADDR_W
DATA_W, 32, data width

Ports:
ap_clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_req  in  1  pulse or level; starts a zero-fill of all entries
flush_busy  out  1  high while the flush sequencer owns the port
r0_valid  in  1  requester 0 access request
r0_ready  out  1  requester 0 access accepted this cycle
r0_we  in  1  1 = write, 0 = read
r0_addr  in  ADDR_W  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_rvalid  out  1  requester 0 read data valid (one-cycle pulse)
r0_rdata  out  DATA_W  requester 0 read data
r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_rvalid, r1_rdata  same as requester 0, for requester 1
rf_we  out  1  register file write enable
rf_addr  out  ADDR_W  register file address
rf_w_data  out  DATA_W  register file write data
rf_r_data  in  DATA_W  register file read data (combinational from rf_addr)

Behaviour:
- Reset values:
  - All outputs 0; FSM = IDLE; flush counter = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, FLUSH.
- IDLE:
  - flush_req=1 -> go to FLUSH next cycle. No requester is granted in that cycle; both readys = 0.
  - Otherwise grant one requester:
    - Only one valid -> grant it.
    - Both valid -> grant the requester not equal to last_grant.
  - On a grant, last_grant updates to the granted index.
  - Grant is combinational: rx_ready = grant & rx_valid.
  - rf_we/rf_addr/rf_w_data are driven from the granted requester.
  - No grant -> rf_we=0, rf_addr=0, rf_w_data=0.
- Transfer: occurs when valid & ready.
  - Write: rf_we=1 that cycle. The entry updates at the clock edge. No response is returned.
  - Read: rf_r_data is registered into rx_rdata. rx_rvalid=1 in the following cycle only.
  - Read latency = 1 cycle after acceptance. Back-to-back reads give one rvalid per cycle.
- rx_rdata holds its last value when rvalid=0.
- Read-after-write in consecutive cycles to the same address returns the new data, because the register file is written at the edge.
- Requesters must hold valid/we/addr/wdata stable until ready. The arbiter does not register requests.
- FLUSH:
  - rf_we=1, rf_addr=cnt, rf_w_data=0; cnt increments by 1 each cycle.
  - flush_busy=1; both readys = 0.
  - After writing cnt = 2**ADDR_W-1: return to IDLE and reset cnt to 0. Duration = 2**ADDR_W cycles.
  - flush_req during FLUSH is ignored; no re-trigger or extension.
  - A response rvalid owed from the cycle before the flush started is still delivered.
- Reset mid-flush aborts immediately: FSM = IDLE, cnt = 0, pending rvalid cleared.

Optional Feature:
REGFILE_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins contention. last_grant is unused and constant. Requester 1 is granted only when r0_valid=0.
- Undefined: round-robin as specified above.
- Flush behaviour is identical in both builds.

Test Plan:
1. Reset, then r0 write addr=2 data=0xDEADBEEF, then r0 read addr=2 -> r0_rvalid one cycle after accept, r0_rdata=0xDEADBEEF; r1_rvalid stays 0.
2. r0 and r1 both valid reads every cycle for 4 cycles -> grants alternate r0,r1,r0,r1; each rvalid 1 cycle after its accept. Fixed-prio build: r0 granted 4 times, r1 never.
3. Fill addrs 0..3 with 0x11,0x22,0x33,0x44, pulse flush_req -> flush_busy=1 for exactly 4 cycles, rf_addr 0,1,2,3 with rf_we=1; subsequent reads of 0..3 return 0.
4. flush_req asserted while r1_valid=1 -> r1_ready=0 until flush_busy falls; r1 is accepted the first IDLE cycle after. flush_req held high re-enters FLUSH instead.
5. Reset asserted at flush cycle 2 -> next cycle flush_busy=0, FSM IDLE; entries 0,1 are zero, entries 2,3 keep their old values.
6. r1 write addr=1 data=0x5A followed next cycle by r0 read addr=1 -> r0_rdata=0x5A.

Source files
------------

// File: rtl/iob_regfile_sp_arb.sv
// Single-port register file controller: two-requester arbiter, read response, zero-fill flush.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module iob_regfile_sp_arb #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              rst,
  input  logic              flush_req,
  output logic              flush_busy,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic [DATA_W-1:0] rf_r_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic last_grant_q, last_grant_d;
  logic r0_rvalid_q, r0_rvalid_d;
  logic r1_rvalid_q, r1_rvalid_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic g0, g1;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b1 & 1'b0;
    if (!rst && state_q == IDLE && !flush_req) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      g0 = r0_valid;
      g1 = r1_valid & ~r0_valid;
`else
      g0 = r0_valid & (~r1_valid | last_grant_q);
      g1 = r1_valid & ~g0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rf_we        = 1'b0;
    rf_addr      = '0;
    rf_w_data    = '0;
    flush_busy   = 1'b0;
    r0_rvalid_d  = g0 & ~r0_we;
    r1_rvalid_d  = g1 & ~r1_we;
    r0_rdata_d   = r0_rvalid_d ? rf_r_data : r0_rdata_q;
    r1_rdata_d   = r1_rvalid_d ? rf_r_data : r1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else if (g0) begin
`ifndef REGFILE_ARB_FIXED_PRIO_EN
          last_grant_d = 1'b0;
`endif
          rf_we     = r0_we;
          rf_addr   = r0_addr;
          rf_w_data = r0_wdata;
        end else if (g1) begin
`ifndef REGFILE_ARB_FIXED_PRIO_EN
          last_grant_d = 1'b1;
`endif
          rf_we     = r1_we;
          rf_addr   = r1_addr;
          rf_w_data = r1_wdata;
        end
      end
      FLUSH: begin
        flush_busy = 1'b1;
        rf_we      = 1'b1;
        rf_addr    = cnt_q;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts a flush in the same cycle, so no further entry is cleared.
    if (rst) begin
      rf_we      = 1'b0;
      rf_addr    = '0;
      rf_w_data  = '0;
      flush_busy = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      r0_rvalid_q  <= 1'b0;
      r1_rvalid_q  <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      r0_rvalid_q  <= r0_rvalid_d;
      r1_rvalid_q  <= r1_rvalid_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
    end
  end

  assign r0_ready  = g0;
  assign r1_ready  = g1;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_iob_regfile_sp_arb.sv
// Directed bench for iob_regfile_sp_arb with a read-response scoreboard.
// Register file modelled here; honours REGFILE_ARB_FIXED_PRIO_EN.
module tb_iob_regfile_sp_arb;

  logic        ap_clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_req = 1'b0;
  logic        flush_busy;
  logic        r0_valid = 1'b0, r0_we = 1'b0;
  logic [1:0]  r0_addr = '0;
  logic [31:0] r0_wdata = '0;
  logic        r0_ready, r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r1_valid = 1'b0, r1_we = 1'b0;
  logic [1:0]  r1_addr = '0;
  logic [31:0] r1_wdata = '0;
  logic        r1_ready, r1_rvalid;
  logic [31:0] r1_rdata;
  logic        rf_we;
  logic [1:0]  rf_addr;
  logic [31:0] rf_w_data;
  logic [31:0] rf_r_data;

  logic [31:0] mem [4] = '{default: 32'h0};

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  logic e0, e1;

  iob_regfile_sp_arb #(.ADDR_W(2), .DATA_W(32)) dut (
    .ap_clk    (ap_clk),
    .rst       (rst),
    .flush_req (flush_req),
    .flush_busy(flush_busy),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_w_data (rf_w_data),
    .rf_r_data (rf_r_data)
  );

  always #5 ap_clk = ~ap_clk;

  assign rf_r_data = mem[rf_addr];

  always @(posedge ap_clk) begin
    if (rf_we) mem[rf_addr] <= rf_w_data;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge ap_clk) begin
    if (!rst) begin
      e0 = (q0.size() > 0) && (q0[0].due == cyc);
      e1 = (q1.size() > 0) && (q1[0].due == cyc);
      chk("r0_rvalid", {31'b0, r0_rvalid}, {31'b0, e0});
      chk("r1_rvalid", {31'b0, r1_rvalid}, {31'b0, e1});
      if (e0) begin
        chk("r0_rdata", r0_rdata, q0[0].d);
        void'(q0.pop_front());
      end
      if (e1) begin
        chk("r1_rdata", r1_rdata, q1[0].d);
        void'(q1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic access(input int p, input logic we, input logic [1:0] a,
                        input logic [31:0] wd, input logic [31:0] exp);
    int   n;
    logic rdy;
    n = 0;
    if (p == 0) begin
      r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd;
    end else begin
      r1_valid = 1'b1; r1_we = we; r1_addr = a; r1_wdata = wd;
    end
    do begin
      @(negedge ap_clk);
      n++;
      rdy = (p == 0) ? r0_ready : r1_ready;
    end while (!rdy && n < 50);
    chk($sformatf("accept_r%0d_a%0d", p, a), {31'b0, rdy}, 32'd1);
    if (rdy && !we) begin
      if (p == 0) q0.push_back('{d: exp, due: cyc + 1});
      else        q1.push_back('{d: exp, due: cyc + 1});
    end
    step();
    if (p == 0) r0_valid = 1'b0;
    else        r1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge ap_clk);
    chk("rst_busy", {31'b0, flush_busy}, 32'd0);
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic g0e;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    chk("rst_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    chk("rst_rf_addr", {30'b0, rf_addr}, 32'd0);
    step();
    rst = 1'b0;

    // 1: write then read through requester 0
    access(0, 1'b1, 2'd2, 32'hDEADBEEF, 32'h0);
    access(0, 1'b0, 2'd2, 32'h0, 32'hDEADBEEF);
    step();

    // 2: contention, four cycles of reads from both
    do_reset();
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 2'd2;
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 2'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      g0e = 1'b1;
`else
      g0e = (k % 2 == 0);
`endif
      chk($sformatf("rr_r0_ready%0d", k), {31'b0, r0_ready}, {31'b0, g0e});
      chk($sformatf("rr_r1_ready%0d", k), {31'b0, r1_ready}, {31'b0, ~g0e});
      if (r0_ready) q0.push_back('{d: 32'hDEADBEEF, due: cyc + 1});
      if (r1_ready) q1.push_back('{d: 32'hDEADBEEF, due: cyc + 1});
      step();
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    step();

    // 3: fill, flush, read back zero
    for (int i = 0; i < 4; i++)
      access(0, 1'b1, 2'(i), 32'(8'h11 * (i + 1)), 32'h0);
    flush_req = 1'b1;
    @(negedge ap_clk);
    chk("fl_start_busy", {31'b0, flush_busy}, 32'd0);
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      chk($sformatf("fl_busy%0d", i), {31'b0, flush_busy}, 32'd1);
      chk($sformatf("fl_we%0d", i), {31'b0, rf_we}, 32'd1);
      chk($sformatf("fl_addr%0d", i), {30'b0, rf_addr}, i);
      chk($sformatf("fl_wdata%0d", i), rf_w_data, 32'd0);
      step();
    end
    @(negedge ap_clk);
    chk("fl_end_busy", {31'b0, flush_busy}, 32'd0);
    step();
    for (int i = 0; i < 4; i++)
      access(1, 1'b0, 2'(i), 32'h0, 32'h0);
    step();

    // 4: flush_req held while r1 waits
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 2'd0;
    flush_req = 1'b1;
    @(negedge ap_clk);
    chk("f4_r1_ready_req", {31'b0, r1_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge ap_clk);
      chk($sformatf("f4_busy%0d", i), {31'b0, flush_busy}, 32'd1);
      chk($sformatf("f4_rdy%0d", i), {31'b0, r1_ready}, 32'd0);
    end
    step();
    @(negedge ap_clk);
    chk("f4_gap_busy", {31'b0, flush_busy}, 32'd0);
    chk("f4_gap_rdy", {31'b0, r1_ready}, 32'd0);
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      chk($sformatf("f4b_busy%0d", i), {31'b0, flush_busy}, 32'd1);
      chk($sformatf("f4b_rdy%0d", i), {31'b0, r1_ready}, 32'd0);
      step();
    end
    @(negedge ap_clk);
    chk("f4_after_busy", {31'b0, flush_busy}, 32'd0);
    chk("f4_after_rdy", {31'b0, r1_ready}, 32'd1);
    if (r1_ready) q1.push_back('{d: 32'h0, due: cyc + 1});
    step();
    r1_valid = 1'b0;
    step();

    // 5: reset during flush cycle 2
    for (int i = 0; i < 4; i++)
      access(0, 1'b1, 2'(i), 32'(8'h11 * (i + 1)), 32'h0);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    @(negedge ap_clk);
    chk("f5_addr0", {30'b0, rf_addr}, 32'd0);
    step();
    @(negedge ap_clk);
    chk("f5_addr1", {30'b0, rf_addr}, 32'd1);
    step();
    rst = 1'b1;
    @(negedge ap_clk);
    chk("f5_rst_we", {31'b0, rf_we}, 32'd0);
    chk("f5_rst_busy", {31'b0, flush_busy}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge ap_clk);
    chk("f5_idle_busy", {31'b0, flush_busy}, 32'd0);
    chk("f5_idle_we", {31'b0, rf_we}, 32'd0);
    step();
    access(0, 1'b0, 2'd0, 32'h0, 32'h0);
    access(0, 1'b0, 2'd1, 32'h0, 32'h0);
    access(0, 1'b0, 2'd2, 32'h0, 32'h33);
    access(0, 1'b0, 2'd3, 32'h0, 32'h44);

    // 6: r1 write followed at once by r0 read
    access(1, 1'b1, 2'd1, 32'h5A, 32'h0);
    access(0, 1'b0, 2'd1, 32'h0, 32'h5A);
    repeat (3) step();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
